// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table response checker.
// Holds the checker state encoding and the expected-output constants for
// the 3-input lab functions (bit i = expected f for input vector value i).
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } tt_state_e;

  // Lab function f = vec==2 | vec>=5 (the default reference table).
  localparam logic [7:0] TT_TRUTH_LAB1    = 8'b1110_0100;
  // 3-input majority.
  localparam logic [7:0] TT_TRUTH_MAJ3    = 8'b1110_1000;
  // 3-input odd parity.
  localparam logic [7:0] TT_TRUTH_XOR3    = 8'b1001_0110;
  localparam logic [7:0] TT_TRUTH_DEFAULT = TT_TRUTH_LAB1;

endpackage

// File: rtl/tt_lookup.sv
// Combinational truth-table lookup: compares the observed output against the
// expected table entry for the applied vector and decodes the vector to a
// one-hot minterm mask.
// Ports:
//   vec      applied input vector (MSB = first function input)
//   f        observed device output
//   truth    expected table, bit i = expected f for vector i
//   mismatch f differs from truth[vec]
//   minterm  one-hot decode of vec
module tt_lookup #(
  parameter int unsigned N_IN = 3
) (
  input  logic [N_IN-1:0]        vec,
  input  logic                   f,
  input  logic [(2**N_IN)-1:0]   truth,
  output logic                   mismatch,
  output logic [(2**N_IN)-1:0]   minterm
);

  always_comb begin
    minterm      = '0;
    minterm[vec] = 1'b1;
    mismatch     = f ^ truth[vec];
  end

endmodule

// File: rtl/tt_response_checker.sv
// Response checker for exhaustive truth-table tests of a small combinational
// block. Compares each sampled output against TRUTH, tracks exercised
// minterms, counts mismatches (saturating) and reports pass/fail once every
// minterm has been seen.
// Optional feature macro: TT_FIRST_FAIL_EN adds a capture of the first
// mismatching vector of the run (first_fail_vld / first_fail_vec).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           pulse: clear results and (re)start a run
//   vec_valid       vec/f are settled and sampled this cycle
//   vec, f          applied vector and device output
//   busy, done      run in progress / run finished
//   pass            finished with zero mismatches
//   err_cnt         mismatch count, saturating
//   coverage        bit i set once vector i has been sampled
module tt_response_checker
  import tt_pkg::*;
#(
  parameter int unsigned              N_IN  = 3,
  parameter logic [(2**N_IN)-1:0]     TRUTH = TT_TRUTH_DEFAULT,
  parameter int unsigned              ERR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   vec_valid,
  input  logic [N_IN-1:0]        vec,
  input  logic                   f,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_cnt,
`ifdef TT_FIRST_FAIL_EN
  output logic                   first_fail_vld,
  output logic [N_IN-1:0]        first_fail_vec,
`endif
  output logic [(2**N_IN)-1:0]   coverage
);

  localparam int unsigned NT = 2**N_IN;

  tt_state_e         state;
  logic              mismatch;
  logic [NT-1:0]     minterm;
  logic              sample;
  logic [ERR_W-1:0]  err_inc;
  logic [ERR_W-1:0]  err_upd;
  logic [NT-1:0]     cov_upd;

  tt_lookup #(.N_IN(N_IN)) u_lookup (
    .vec      (vec),
    .f        (f),
    .truth    (TRUTH),
    .mismatch (mismatch),
    .minterm  (minterm)
  );

  // Next-value helpers for the result registers while checking.
  always_comb begin
    sample  = 1'b0;
    err_inc = err_cnt;
    err_upd = err_cnt;
    cov_upd = coverage;
    sample  = vec_valid && (state == CHECK);
    if (err_cnt != {ERR_W{1'b1}}) begin
      err_inc = err_cnt + ERR_W'(1);
    end
    if (sample && mismatch) begin
      err_upd = err_inc;
    end
    if (sample) begin
      cov_upd = coverage | minterm;
    end
  end

  // Checker FSM and result registers; start takes priority over sampling.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      coverage       <= '0;
`ifdef TT_FIRST_FAIL_EN
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
`endif
    end else if (start) begin
      state          <= CHECK;
      busy           <= 1'b1;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      coverage       <= '0;
`ifdef TT_FIRST_FAIL_EN
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
`endif
    end else begin
      case (state)
        CHECK: begin
          err_cnt  <= err_upd;
          coverage <= cov_upd;
`ifdef TT_FIRST_FAIL_EN
          if (sample && mismatch && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_vec <= vec;
          end
`endif
          // Coverage completed on the previous edge: finish this edge.
          if (&coverage) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_upd == '0);
          end
        end
        IDLE, DONE: begin
          state <= state;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tt_response_checker.md
# tt_response_checker

Hardware response checker for exhaustive truth-table tests of small combinational blocks. It observes each applied input vector and the block's output, compares the output against a parameterised expected truth table, tracks which minterms have been exercised, counts mismatches and raises pass/fail once every minterm has been seen. It sits on the receiving end of a stimulus sequencer, between the device under test and the lab board LEDs or simulation log.

## Interface
- `N_IN`, default 3: number of function inputs; truth table has 2^N_IN entries.
- `TRUTH`, default 8'b1110_0100: expected output; bit i is the expected f for input vector value i (MSB of `vec` = first input).
- `ERR_W`, default 4: error counter width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  single-cycle pulse; clears results and begins a check run.
- `vec_valid`  in  1  `vec` and `f` are settled and must be sampled this cycle.
- `vec`  in  N_IN  applied input vector.
- `f`  in  1  output of the device under test.
- `busy`  out  1  high in CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when `err_cnt` == 0.
- `err_cnt`  out  ERR_W  mismatches this run; saturates at all-ones.
- `coverage`  out  2^N_IN  bit i set once vector i has been sampled this run.

## Operation
- States: IDLE, CHECK, DONE.
- IDLE: `vec_valid` ignored. `start` -> CHECK, clearing `err_cnt`, `coverage`, `pass`.
- CHECK: on `vec_valid`, set `coverage[vec]`; if `f != TRUTH[vec]`, increment `err_cnt` (hold at 2^ERR_W-1). Duplicate vectors are compared and counted again; coverage unchanged.
- CHECK -> DONE in the cycle after `coverage` becomes all-ones.
- DONE: outputs hold; `vec_valid` ignored. `start` -> CHECK with results cleared.
- `start` during CHECK: restart. Results are cleared and the run begins again in CHECK. `start` wins over a coincident `vec_valid`; that sample is discarded.
- `pass` is computed when entering DONE and is 0 in every other state.

## Timing
- Reset (`rst_n` low at a clock edge) has priority over every other input and may be asserted mid-run. It forces IDLE, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `coverage`=0.
- Sample at edge k, where `vec_valid`=1 and the block is in CHECK: `coverage` and `err_cnt` reflect it after edge k, so they are visible in cycle k+1.
- The sample at edge k that completes coverage: `done`/`pass` are high after edge k+1, giving one cycle of latency from completing coverage to DONE.
- `start` at edge k: `busy`=1 and results are cleared in cycle k+1.
- Minimum run length is 2^N_IN consecutive `vec_valid` cycles plus 1.
- The block does not qualify stimulus settling; the sender asserts `vec_valid` only after the DUT output has settled.

## Configuration
- `TT_FIRST_FAIL_EN` defined: adds outputs `first_fail_vld` (1 bit) and `first_fail_vec` (N_IN bits).
  - `first_fail_vld` is set on the first mismatch of the run, and `first_fail_vec` captures that `vec`.
  - Later mismatches do not overwrite the capture.
  - Both are cleared by reset and by `start`.
- `TT_FIRST_FAIL_EN` undefined: these ports and registers do not exist. All other behaviour is identical.

## Structure
- A shared package `tt_pkg` holds:
  - the state encoding constants (IDLE=2'd0, CHECK=2'd1, DONE=2'd2);
  - the default `TRUTH` constants for the lab functions.
- One sub-module, `tt_lookup`: combinational; takes `vec`, `f`, `TRUTH` and outputs `mismatch` and a one-hot minterm decode. The top-level block holds the FSM, the coverage register and the counters.

## Test plan
- Correct DUT model: `start`, then vectors 0..7 in order, each with `f`=TRUTH[i] -> `coverage`=8'hFF, `err_cnt`=0, `done`=1 and `pass`=1 one cycle after the last sample.
- Two faults: as above, but `f` inverted at vectors 2 and 5 -> `err_cnt`=2, `pass`=0. With `TT_FIRST_FAIL_EN`: `first_fail_vec`=3'd2 and `first_fail_vld`=1.
- Saturation: ERR_W=2; send vector 1 with a wrong `f` five times, then vectors 0..7 all correct -> `err_cnt`=3, `done`=1, `pass`=0.
- Mid-run restart: `start`; vectors 0..3 with vector 1 wrong; `start` again together with `vec_valid` -> `err_cnt`=0 and `coverage`=0 in the next cycle. A full correct sweep then gives `pass`=1.
- Reset mid-run: `rst_n` low for one edge after 4 samples -> IDLE, all outputs 0. Subsequent `vec_valid` without `start` leaves `coverage`=0.
- Ignored inputs: `vec_valid` pulses in IDLE and in DONE -> `err_cnt` and `coverage` unchanged. Reversed order 7..0 -> DONE one cycle after vector 0.
